// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel run-time divisors, 1-cycle tick strobes and square waves.
// Optional macro CLKEN_RESYNC_EN adds a resync input that zeroes every channel's phase in one cycle.
module clock_enable_gen #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 25,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {25'd8388608, 25'd262144, 25'd4}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
`ifdef CLKEN_RESYNC_EN
  input  logic              resync,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_imm,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

  // Config handshake: a transfer happens on a cycle with cfg_valid && cfg_ready;
  // cfg_valid may be held until it is taken, and cfg_ready is low only while the slot is occupied.
  logic             pending;
  logic [3:0]       slot_ch;
  logic [DIV_W-1:0] slot_div;

  logic [DIV_W-1:0] cnt     [NUM_CH];
  logic [DIV_W-1:0] div     [NUM_CH];
  logic [DIV_W-1:0] cnt_nxt [NUM_CH];
  logic [DIV_W-1:0] div_nxt [NUM_CH];
  logic [DIV_W-1:0] half    [NUM_CH];

  logic [NUM_CH-1:0] imm_hit, wrap, slot_hit, apply, clr, tick_nxt, sq_nxt;
  logic xfer, bad_ch, def_load, pend_nxt, resync_i;

  function automatic logic [DIV_W-1:0] fix_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

`ifdef CLKEN_RESYNC_EN
  assign resync_i = resync;
`else
  assign resync_i = 1'b0;
`endif

  assign cfg_ready = !pending;
  assign xfer      = cfg_valid && cfg_ready;
  assign bad_ch    = {1'b0, cfg_ch} >= NUM_CH_L;
  assign def_load  = xfer && !cfg_imm && !bad_ch;

  always_comb begin
    pend_nxt = pending;
    for (int i = 0; i < NUM_CH; i++) begin
      imm_hit[i]  = xfer && cfg_imm && !bad_ch && (cfg_ch == i[3:0]);
      wrap[i]     = en && (cnt[i] == div[i] - DIV_W'(1));
      slot_hit[i] = pending && (slot_ch == i[3:0]);
      apply[i]    = slot_hit[i] && wrap[i];
      clr[i]      = imm_hit[i] || resync_i;
      half[i]     = (div[i] >> 1) + {{(DIV_W-1){1'b0}}, div[i][0]};

      if (clr[i])       cnt_nxt[i] = '0;
      else if (wrap[i]) cnt_nxt[i] = '0;
      else if (en)      cnt_nxt[i] = cnt[i] + DIV_W'(1);
      else              cnt_nxt[i] = cnt[i];

      // An immediate load overrides a deferred value that happens to land on the same edge.
      if (imm_hit[i])     div_nxt[i] = fix_div(cfg_div);
      else if (apply[i])  div_nxt[i] = slot_div;
      else                div_nxt[i] = div[i];

      tick_nxt[i] = !clr[i] && wrap[i];
      if (clr[i])      sq_nxt[i] = 1'b0;
      else if (en)     sq_nxt[i] = (cnt_nxt[i] >= half[i]);
      else             sq_nxt[i] = sq_o[i];
    end
    if (|apply || |(slot_hit & imm_hit)) pend_nxt = 1'b0;
    if (def_load)                        pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= fix_div(DIV_INIT[i*DIV_W +: DIV_W]);
      end
      tick_o   <= '0;
      sq_o     <= '0;
      pending  <= 1'b0;
      slot_ch  <= '0;
      slot_div <= DIV_W'(1);
      cfg_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        div[i] <= div_nxt[i];
      end
      tick_o  <= tick_nxt;
      sq_o    <= sq_nxt;
      pending <= pend_nxt;
      if (def_load) begin
        slot_ch  <= cfg_ch;
        slot_div <= fix_div(cfg_div);
      end
      if (xfer && bad_ch) cfg_err <= 1'b1;
    end
  end

endmodule
